// File: rtl/iter_shift_unit.sv
// Multi-cycle shifter (SLL/SRL/SRA/ROL), up to STEP positions per clock, valid/ready on both sides.
// Define ITER_SHIFT_CARRY_EN to add the carry_out port (last bit shifted out).
module iter_shift_unit #(
  parameter int unsigned WIDTH   = 32,
  parameter int unsigned STEP    = 1,
  parameter int unsigned SHAMT_W = $clog2(WIDTH)
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [WIDTH-1:0]   data_in,
  input  logic [SHAMT_W-1:0] shamt,
  input  logic [1:0]         mode,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [WIDTH-1:0]   data_out,
  output logic               busy
`ifdef ITER_SHIFT_CARRY_EN
  ,
  output logic               carry_out
`endif
);

  localparam int unsigned CW = SHAMT_W + 1;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_SHIFT = 2'd1;
  localparam logic [1:0] ST_DONE  = 2'd2;

  localparam logic [1:0] MODE_SLL = 2'b00;
  localparam logic [1:0] MODE_SRL = 2'b01;
  localparam logic [1:0] MODE_SRA = 2'b10;

  logic [1:0]         state_q, state_d;
  logic [WIDTH-1:0]   work_q, work_d;
  logic [SHAMT_W-1:0] rem_q, rem_d;
  logic [1:0]         mode_q, mode_d;
  logic               sign_q, sign_d;
  logic [WIDTH-1:0]   dout_q, dout_d;
  logic               in_ready_q, in_ready_d;
  logic               out_valid_q, out_valid_d;
  logic               busy_q, busy_d;

  logic [CW-1:0]      k_c;
  logic [WIDTH-1:0]   shift_val_c;

  // Positions moved this cycle: min(STEP, remaining), wide enough to hold STEP==WIDTH.
  always_comb begin
    k_c = CW'(STEP);
    if ({1'b0, rem_q} < CW'(STEP)) begin
      k_c = {1'b0, rem_q};
    end
  end

  // One-position shift chain, enabled for the first k_c positions.
  always_comb begin
    shift_val_c = work_q;
    for (int unsigned i = 0; i < STEP; i++) begin
      if (CW'(i) < k_c) begin
        case (mode_q)
          MODE_SLL: shift_val_c = {shift_val_c[WIDTH-2:0], 1'b0};
          MODE_SRL: shift_val_c = {1'b0, shift_val_c[WIDTH-1:1]};
          MODE_SRA: shift_val_c = {sign_q, shift_val_c[WIDTH-1:1]};
          default:  shift_val_c = {shift_val_c[WIDTH-2:0], shift_val_c[WIDTH-1]};
        endcase
      end
    end
  end

`ifdef ITER_SHIFT_CARRY_EN
  logic               carry_q, carry_d;
  logic [SHAMT_W-1:0] cy_idx_c;
  logic               cy_c;

  // Left modes lose bit WIDTH-k last, right modes lose bit k-1 last (modulo WIDTH index).
  always_comb begin
    if (mode_q == MODE_SLL || mode_q == 2'b11) begin
      cy_idx_c = SHAMT_W'(0) - k_c[SHAMT_W-1:0];
    end else begin
      cy_idx_c = k_c[SHAMT_W-1:0] - SHAMT_W'(1);
    end
    cy_c = work_q[cy_idx_c];
  end
`endif

  // Next-state and registered-output logic.
  always_comb begin
    state_d = state_q;
    work_d  = work_q;
    rem_d   = rem_q;
    mode_d  = mode_q;
    sign_d  = sign_q;
    dout_d  = dout_q;
`ifdef ITER_SHIFT_CARRY_EN
    carry_d = carry_q;
`endif
    case (state_q)
      ST_IDLE: begin
        if (in_valid && in_ready_q) begin
          work_d = data_in;
          mode_d = mode;
          sign_d = data_in[WIDTH-1];
          rem_d  = shamt;
`ifdef ITER_SHIFT_CARRY_EN
          carry_d = 1'b0;
`endif
          if (shamt == '0) begin
            dout_d  = data_in;
            state_d = ST_DONE;
          end else begin
            state_d = ST_SHIFT;
          end
        end
      end
      ST_SHIFT: begin
        work_d = shift_val_c;
        rem_d  = rem_q - SHAMT_W'(k_c);
`ifdef ITER_SHIFT_CARRY_EN
        carry_d = cy_c;
`endif
        if (rem_d == '0) begin
          dout_d  = shift_val_c;
          state_d = ST_DONE;
        end
      end
      ST_DONE: begin
        if (out_ready) begin
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
    in_ready_d  = (state_d == ST_IDLE);
    out_valid_d = (state_d == ST_DONE);
    busy_d      = (state_d != ST_IDLE);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      work_q      <= '0;
      rem_q       <= '0;
      mode_q      <= '0;
      sign_q      <= 1'b0;
      dout_q      <= '0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
      busy_q      <= 1'b0;
`ifdef ITER_SHIFT_CARRY_EN
      carry_q     <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      work_q      <= work_d;
      rem_q       <= rem_d;
      mode_q      <= mode_d;
      sign_q      <= sign_d;
      dout_q      <= dout_d;
      in_ready_q  <= in_ready_d;
      out_valid_q <= out_valid_d;
      busy_q      <= busy_d;
`ifdef ITER_SHIFT_CARRY_EN
      carry_q     <= carry_d;
`endif
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign busy      = busy_q;
  assign data_out  = dout_q;
`ifdef ITER_SHIFT_CARRY_EN
  assign carry_out = carry_q;
`endif

endmodule

// File: tb/tb_iter_shift_unit.sv
// Directed + randomised bench for iter_shift_unit; three instances with STEP = 1, 4, 32 share one stimulus.
module tb_iter_shift_unit;

  localparam int N = 3;
  localparam int STEP_OF [N] = '{1, 4, 32};

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid;
  logic        out_ready;
  logic [31:0] data_in;
  logic [4:0]  shamt;
  logic [1:0]  mode;

  logic [N-1:0] in_ready;
  logic [N-1:0] out_valid;
  logic [N-1:0] busy;
  logic [31:0]  data_out [N];
`ifdef ITER_SHIFT_CARRY_EN
  logic [N-1:0] carry_out;
`endif

  int checks = 0;
  int errors = 0;

  int          lat_r [N];
  logic [31:0] res_r [N];
  logic        car_r [N];

  always #5 clk = ~clk;

  iter_shift_unit #(.WIDTH(32), .STEP(1)) u_s1 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready[0]),
    .data_in(data_in), .shamt(shamt), .mode(mode), .out_valid(out_valid[0]),
    .out_ready(out_ready), .data_out(data_out[0]), .busy(busy[0])
`ifdef ITER_SHIFT_CARRY_EN
    , .carry_out(carry_out[0])
`endif
  );

  iter_shift_unit #(.WIDTH(32), .STEP(4)) u_s4 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready[1]),
    .data_in(data_in), .shamt(shamt), .mode(mode), .out_valid(out_valid[1]),
    .out_ready(out_ready), .data_out(data_out[1]), .busy(busy[1])
`ifdef ITER_SHIFT_CARRY_EN
    , .carry_out(carry_out[1])
`endif
  );

  iter_shift_unit #(.WIDTH(32), .STEP(32)) u_s32 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready[2]),
    .data_in(data_in), .shamt(shamt), .mode(mode), .out_valid(out_valid[2]),
    .out_ready(out_ready), .data_out(data_out[2]), .busy(busy[2])
`ifdef ITER_SHIFT_CARRY_EN
    , .carry_out(carry_out[2])
`endif
  );

  // Issue one request, record first out_valid cycle/data per instance (999 = never seen).
  task automatic run_req(input logic [31:0] d, input logic [4:0] s, input logic [1:0] m,
                         input bit rnd_rdy);
    bit done [N];
    int cyc;
    for (int i = 0; i < N; i++) begin
      done[i]  = 1'b0;
      lat_r[i] = 999;
      res_r[i] = '0;
      car_r[i] = 1'b0;
    end
    data_in   = d;
    shamt     = s;
    mode      = m;
    in_valid  = 1'b1;
    out_ready = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    data_in  = ~d;
    shamt    = ~s;
    mode     = ~m;
    cyc = 1;
    while (cyc < 200) begin
      for (int i = 0; i < N; i++) begin
        if (!done[i] && out_valid[i]) begin
          done[i]  = 1'b1;
          lat_r[i] = cyc;
          res_r[i] = data_out[i];
`ifdef ITER_SHIFT_CARRY_EN
          car_r[i] = carry_out[i];
`endif
        end
      end
      if (done[0] && done[1] && done[2]) break;
      if (rnd_rdy) out_ready = 1'($urandom_range(0, 1));
      @(posedge clk); #1;
      cyc++;
    end
    out_ready = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_reset();
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    out_ready = 1'b1;
    data_in   = '0;
    shamt     = '0;
    mode      = '0;
    repeat (2) @(posedge clk);
    #1;
    for (int i = 0; i < N; i++) begin
      checks++;
      if (in_ready[i] !== 1'b1 || out_valid[i] !== 1'b0 || busy[i] !== 1'b0 || data_out[i] !== 32'h0) begin
        errors++;
        $display("FAIL reset dut%0d: rdy=%b ov=%b busy=%b dout=%h, want 1 0 0 0", i, in_ready[i],
                 out_valid[i], busy[i], data_out[i]);
      end
`ifdef ITER_SHIFT_CARRY_EN
      checks++;
      if (carry_out[i] !== 1'b0) begin
        errors++;
        $display("FAIL reset_carry dut%0d: got %b want 0", i, carry_out[i]);
      end
`endif
    end
    rst_n = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_sll_branch();
    int el [N];
    el = '{3, 2, 2};
    run_req(32'h0000_0003, 5'd2, 2'b00, 1'b0);
    for (int i = 0; i < N; i++) begin
      checks++;
      if (res_r[i] !== 32'h0000_000C) begin
        errors++;
        $display("FAIL sll_data dut%0d: got %h want 0000000c", i, res_r[i]);
      end
      checks++;
      if (lat_r[i] != el[i]) begin
        errors++;
        $display("FAIL sll_latency dut%0d: got %0d want %0d", i, lat_r[i], el[i]);
      end
`ifdef ITER_SHIFT_CARRY_EN
      checks++;
      if (car_r[i] !== 1'b0) begin
        errors++;
        $display("FAIL sll_carry dut%0d: got %b want 0", i, car_r[i]);
      end
`endif
    end
  endtask

  task automatic test_sra_partial_step();
    int el [N];
    el = '{7, 3, 2};
    run_req(32'h8000_00F0, 5'd6, 2'b10, 1'b0);
    for (int i = 0; i < N; i++) begin
      checks++;
      if (res_r[i] !== 32'hFE00_0003) begin
        errors++;
        $display("FAIL sra_data dut%0d: got %h want fe000003", i, res_r[i]);
      end
      checks++;
      if (lat_r[i] != el[i]) begin
        errors++;
        $display("FAIL sra_latency dut%0d: got %0d want %0d", i, lat_r[i], el[i]);
      end
`ifdef ITER_SHIFT_CARRY_EN
      checks++;
      if (car_r[i] !== 1'b1) begin
        errors++;
        $display("FAIL sra_carry dut%0d: got %b want 1", i, car_r[i]);
      end
`endif
    end
  endtask

  task automatic test_rol_and_zero();
    run_req(32'h8000_0001, 5'd1, 2'b11, 1'b0);
    for (int i = 0; i < N; i++) begin
      checks++;
      if (res_r[i] !== 32'h0000_0003 || lat_r[i] != 2) begin
        errors++;
        $display("FAIL rol1 dut%0d: got %h lat %0d want 00000003 lat 2", i, res_r[i], lat_r[i]);
      end
`ifdef ITER_SHIFT_CARRY_EN
      checks++;
      if (car_r[i] !== 1'b1) begin
        errors++;
        $display("FAIL rol1_carry dut%0d: got %b want 1", i, car_r[i]);
      end
`endif
    end
    run_req(32'h1234_5678, 5'd0, 2'b11, 1'b0);
    for (int i = 0; i < N; i++) begin
      checks++;
      if (res_r[i] !== 32'h1234_5678 || lat_r[i] != 1) begin
        errors++;
        $display("FAIL zero_shamt dut%0d: got %h lat %0d want 12345678 lat 1", i, res_r[i], lat_r[i]);
      end
`ifdef ITER_SHIFT_CARRY_EN
      checks++;
      if (car_r[i] !== 1'b0) begin
        errors++;
        $display("FAIL zero_carry dut%0d: got %b want 0", i, car_r[i]);
      end
`endif
    end
  endtask

  task automatic test_boundary();
    int el [N];
    el = '{32, 9, 2};
    run_req(32'h8000_0000, 5'd31, 2'b01, 1'b0);
    for (int i = 0; i < N; i++) begin
      checks++;
      if (res_r[i] !== 32'h0000_0001 || lat_r[i] != el[i]) begin
        errors++;
        $display("FAIL srl31 dut%0d: got %h lat %0d want 00000001 lat %0d", i, res_r[i], lat_r[i], el[i]);
      end
    end
    run_req(32'hFFFF_FFFF, 5'd31, 2'b00, 1'b0);
    for (int i = 0; i < N; i++) begin
      checks++;
      if (res_r[i] !== 32'h8000_0000 || lat_r[i] != el[i]) begin
        errors++;
        $display("FAIL sll31 dut%0d: got %h lat %0d want 80000000 lat %0d", i, res_r[i], lat_r[i], el[i]);
      end
`ifdef ITER_SHIFT_CARRY_EN
      checks++;
      if (car_r[i] !== 1'b1) begin
        errors++;
        $display("FAIL sll31_carry dut%0d: got %b want 1", i, car_r[i]);
      end
`endif
    end
    run_req(32'h8000_0000, 5'd31, 2'b10, 1'b0);
    for (int i = 0; i < N; i++) begin
      checks++;
      if (res_r[i] !== 32'hFFFF_FFFF) begin
        errors++;
        $display("FAIL sra31 dut%0d: got %h want ffffffff", i, res_r[i]);
      end
`ifdef ITER_SHIFT_CARRY_EN
      checks++;
      if (car_r[i] !== 1'b0) begin
        errors++;
        $display("FAIL sra31_carry dut%0d: got %b want 0", i, car_r[i]);
      end
`endif
    end
  endtask

  task automatic test_backpressure();
    int cyc;
    out_ready = 1'b0;
    data_in   = 32'hFFFF_FFFF;
    shamt     = 5'd31;
    mode      = 2'b01;
    in_valid  = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    cyc = 0;
    while (out_valid !== 3'b111 && cyc < 100) begin
      @(posedge clk); #1;
      cyc++;
    end
    checks++;
    if (out_valid !== 3'b111) begin
      errors++;
      $display("FAIL bp_timeout: out_valid=%b want 111", out_valid);
    end
    for (int k = 0; k < 10; k++) begin
      for (int i = 0; i < N; i++) begin
        checks++;
        if (out_valid[i] !== 1'b1 || data_out[i] !== 32'h1 || in_ready[i] !== 1'b0 || busy[i] !== 1'b1) begin
          errors++;
          $display("FAIL bp_hold dut%0d cyc%0d: ov=%b dout=%h rdy=%b busy=%b want 1 00000001 0 1", i, k,
                   out_valid[i], data_out[i], in_ready[i], busy[i]);
        end
      end
      in_valid = (k == 3);
      data_in  = 32'hAAAA_5555;
      shamt    = 5'd3;
      @(posedge clk); #1;
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    @(posedge clk); #1;
    for (int i = 0; i < N; i++) begin
      checks++;
      if (out_valid[i] !== 1'b0 || in_ready[i] !== 1'b1 || busy[i] !== 1'b0 || data_out[i] !== 32'h1) begin
        errors++;
        $display("FAIL bp_release dut%0d: ov=%b rdy=%b busy=%b dout=%h want 0 1 0 00000001", i,
                 out_valid[i], in_ready[i], busy[i], data_out[i]);
      end
    end
    @(posedge clk); #1;
    checks++;
    if (busy !== 3'b000 || out_valid !== 3'b000) begin
      errors++;
      $display("FAIL bp_ignored_req: busy=%b ov=%b want 000 000", busy, out_valid);
    end
  endtask

  task automatic test_reset_mid_shift();
    out_ready = 1'b1;
    data_in   = 32'h0000_0001;
    shamt     = 5'd20;
    mode      = 2'b00;
    in_valid  = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    for (int k = 0; k < 5; k++) begin
      checks++;
      if (busy[0] !== 1'b1 || out_valid[0] !== 1'b0) begin
        errors++;
        $display("FAIL mid_shift cyc%0d: busy=%b ov=%b want 1 0", k, busy[0], out_valid[0]);
      end
      @(posedge clk); #1;
    end
    rst_n = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    for (int i = 0; i < N; i++) begin
      checks++;
      if (in_ready[i] !== 1'b1 || out_valid[i] !== 1'b0 || busy[i] !== 1'b0 || data_out[i] !== 32'h0) begin
        errors++;
        $display("FAIL mid_reset dut%0d: rdy=%b ov=%b busy=%b dout=%h want 1 0 0 0", i, in_ready[i],
                 out_valid[i], busy[i], data_out[i]);
      end
    end
    for (int k = 0; k < 20; k++) begin
      @(posedge clk); #1;
      checks++;
      if (out_valid[0] !== 1'b0 || busy[0] !== 1'b0) begin
        errors++;
        $display("FAIL mid_reset_quiet cyc%0d: ov=%b busy=%b want 0 0", k, out_valid[0], busy[0]);
      end
    end
  endtask

  task automatic test_random();
    logic [31:0] d, exp_d;
    logic [4:0]  s;
    logic [1:0]  m;
    logic        exp_c;
    int          el;
    for (int n = 0; n < 600; n++) begin
      d = $urandom;
      s = 5'($urandom_range(0, 31));
      m = 2'($urandom_range(0, 3));
      case (m)
        2'b00:   exp_d = d << s;
        2'b01:   exp_d = d >> s;
        2'b10:   exp_d = 32'($signed(d) >>> s);
        default: exp_d = (s == 5'd0) ? d : ((d << s) | (d >> (6'd32 - {1'b0, s})));
      endcase
      if (s == 5'd0)                     exp_c = 1'b0;
      else if (m == 2'b00 || m == 2'b11) exp_c = d[32 - int'(s)];
      else                               exp_c = d[int'(s) - 1];
      run_req(d, s, m, 1'b1);
      for (int i = 0; i < N; i++) begin
        el = (s == 5'd0) ? 1 : (int'(s) + STEP_OF[i] - 1) / STEP_OF[i] + 1;
        checks++;
        if (res_r[i] !== exp_d || lat_r[i] != el) begin
          errors++;
          $display("FAIL rand%0d dut%0d m=%0d s=%0d d=%h: got %h lat %0d want %h lat %0d", n, i, m, s, d,
                   res_r[i], lat_r[i], exp_d, el);
        end
`ifdef ITER_SHIFT_CARRY_EN
        checks++;
        if (car_r[i] !== exp_c) begin
          errors++;
          $display("FAIL rand%0d_carry dut%0d: got %b want %b", n, i, car_r[i], exp_c);
        end
`else
        if (exp_c === 1'bx) $display("note: undefined model carry");
`endif
      end
    end
  endtask

  initial begin
    test_reset();
    test_sll_branch();
    test_sra_partial_step();
    test_rol_and_zero();
    test_boundary();
    test_backpressure();
    test_reset_mid_shift();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
